piso_shift_tx: RTL

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/mac_pkg.sv | 12 +
 rtl/piso_bit_counter.sv | 28 ++
 rtl/piso_shift_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package mac_pkg;

    localparam int DEFAULT_WORD_LENGTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serializer: synchronous clear, increment, and a flag
// that is high while the last bit of a word is on the line.
module piso_bit_counter #(
    parameter int TOTAL_BITS = 16,
    parameter int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (incr) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign terminal = (count_reg == CNT_W'(TOTAL_BITS - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter, MSB first, stalls while enable is low.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx
    import mac_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   load_valid,
    input  logic [WORD_LENGTH-1:0] Data_Input,
    output logic                   load_ready,
    output logic                   Serial_Output,
    output logic                   Serial_Valid,
    output logic                   done
);

`ifdef PISO_PARITY_EN
    localparam int TOTAL_BITS = WORD_LENGTH + 1;
`else
    localparam int TOTAL_BITS = WORD_LENGTH;
`endif
    localparam int CNT_W = $clog2(WORD_LENGTH + 1);

    tx_state_t             state_reg;
    logic [TOTAL_BITS-1:0] shift_reg;
    logic [TOTAL_BITS-1:0] load_word;
    logic                  load_ready_reg;
    logic                  serial_valid_reg;
    logic                  done_reg;
    logic                  accept;
    logic                  advance;
    logic                  last_bit;

    // Parity rides at the bottom of the shift register so it leaves last.
`ifdef PISO_PARITY_EN
    assign load_word = {Data_Input, ^Data_Input};
`else
    assign load_word = Data_Input;
`endif

    assign accept  = load_ready_reg && load_valid;
    assign advance = (state_reg == SHIFT) && enable;

    piso_bit_counter #(
        .TOTAL_BITS (TOTAL_BITS),
        .CNT_W      (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .incr     (advance),
        .terminal (last_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            shift_reg        <= '0;
            load_ready_reg   <= 1'b1;
            serial_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg        <= SHIFT;
                        shift_reg        <= load_word;
                        load_ready_reg   <= 1'b0;
                        serial_valid_reg <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        shift_reg <= {shift_reg[TOTAL_BITS-2:0], 1'b0};
                        if (last_bit) begin
                            state_reg        <= DONE;
                            serial_valid_reg <= 1'b0;
                            done_reg         <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    done_reg       <= 1'b0;
                    load_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg        <= IDLE;
                    shift_reg        <= '0;
                    load_ready_reg   <= 1'b1;
                    serial_valid_reg <= 1'b0;
                    done_reg         <= 1'b0;
                end
            endcase
        end
    end

    // The register is zero-filled, so the line idles low outside SHIFT.
    assign Serial_Output = shift_reg[TOTAL_BITS-1];
    assign Serial_Valid  = serial_valid_reg;
    assign load_ready    = load_ready_reg;
    assign done          = done_reg;

endmodule
